// File: rtl/cla_sub_serial.sv
// Digit-serial unsigned subtractor: D = A - B - bin, one 4-bit lookahead slice per clock, LSB first.
// Optional signed-overflow output enabled by defining CLA_SUB_SIGNED_OVF_EN.
module cla_sub_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef CLA_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NumSlices = WIDTH / 4;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, d_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  logic              bout_q;
  logic              ovf_q;

  logic [3:0] a_nib, nb_nib, g, p, sum;
  logic [4:0] c;
  logic       last_slice;

  assign last_slice = (cnt_q == LastCnt);

  // Subtraction as A + ~B + ~bin; carry chain is flattened G/P lookahead.
  always_comb begin
    a_nib  = a_q[{cnt_q, 2'b00} +: 4];
    nb_nib = ~b_q[{cnt_q, 2'b00} +: 4];
    g      = a_nib & nb_nib;
    p      = a_nib ^ nb_nib;
    c[0]   = carry_q;
    c[1]   = g[0] | (p[0] & c[0]);
    c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum    = p ^ c[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle:  in_ready = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ~bin;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          d_q[{cnt_q, 2'b00} +: 4] <= sum;
          carry_q                  <= c[4];
          cnt_q                    <= cnt_q + CntW'(1);
          if (last_slice) begin
            bout_q <= ~c[4];
            ovf_q  <= c[3] ^ c[4];
          end
        end
        default: ;
      endcase
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
`ifdef CLA_SUB_SIGNED_OVF_EN
  assign ovf  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_sub_serial.sv
// Self-checking bench for cla_sub_serial: 16-bit instance against a cycle-level model,
// plus an exhaustive sweep of a 4-bit instance.
module tb_cla_sub_serial;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  // 16-bit DUT
  logic          in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [W-1:0]  a, b, d;
  // 4-bit DUT
  logic          iv4, ir4, ov4, or4, bin4, bout4;
  logic [3:0]    a4, b4, d4;
`ifdef CLA_SUB_SIGNED_OVF_EN
  logic          ovf, ovf4;
`endif

  cla_sub_serial #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout)
`ifdef CLA_SUB_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  cla_sub_serial #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .bin(bin4), .out_valid(ov4), .out_ready(or4),
    .d(d4), .bout(bout4)
`ifdef CLA_SUB_SIGNED_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed_ovf(input int av, input int bv, input int bi, input int w);
    int s;
    int lo;
    int hi;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    s  = av - bv - bi;
    return (s < lo) || (s > hi);
  endfunction

  // Behavioural model: a transaction is busy from accept until consumed,
  // result visible NS cycles after accept.
  logic        m_busy, m_done, m_seen, m_ovf;
  int          m_age;
  logic [W:0]  m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_seen <= 1'b0;
      m_age  <= 0;
      m_exp  <= '0;
      m_ovf  <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_seen <= 1'b1;
        m_age  <= 0;
        m_exp  <= {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        m_ovf  <= signed_ovf(int'($signed(a)), int'($signed(b)), int'({31'b0, bin}), W);
      end
    end else if (!m_done) begin
      m_age <= m_age + 1;
      if (m_age + 1 == NS) m_done <= 1'b1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_done});
      if (m_done) begin
        check("d", {16'b0, d}, {16'b0, m_exp[W-1:0]});
        check("bout", {31'b0, bout}, {31'b0, m_exp[W]});
`ifdef CLA_SUB_SIGNED_OVF_EN
        check("ovf", {31'b0, ovf}, {31'b0, m_ovf});
`endif
      end else if (!m_seen) begin
        check("idle d", {16'b0, d}, 32'h0);
        check("idle bout", {31'b0, bout}, 32'h0);
      end
    end
  end

  task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, input logic [15:0] exp_d, input logic exp_b,
                        input logic exp_ovf);
    int lat;
    @(posedge clk); #1;
    a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (out_valid) break;
      @(posedge clk); #1;
      if (out_valid) lat = n;
    end
    check({name, " latency"}, lat, NS);
    check({name, " d"}, {16'b0, d}, {16'b0, exp_d});
    check({name, " bout"}, {31'b0, bout}, {31'b0, exp_b});
`ifdef CLA_SUB_SIGNED_OVF_EN
    check({name, " ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("unused");
`endif
  endtask

  initial begin
    logic [15:0] hold_d;
    logic [4:0]  e4;
    logic        got;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", {31'b0, in_ready}, 32'h1);
    check("rst out_valid", {31'b0, out_valid}, 32'h0);
    check("rst d", {16'b0, d}, 32'h0);
    check("rst bout", {31'b0, bout}, 32'h0);

    run_op("t1234", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("eqbin", 16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("eq", 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_op("sovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);

    // Backpressure with stray operand pulses while busy
    @(posedge clk); #1;
    a = 16'hBEEF; b = 16'h1234; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      got = out_valid;
    end
    check("bp reached done", {31'b0, got}, 32'h1);
    hold_d = d;
    for (int n = 0; n < 10; n++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid = n[0];
      @(posedge clk); #1;
      check("bp in_ready", {31'b0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    check("bp d", {16'b0, d}, 32'hACBB);
    check("bp d stable", {16'b0, d}, {16'b0, hold_d});
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready", {31'b0, in_ready}, 32'h1);

    // Reset during the second RUN cycle
    a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'b0, out_valid}, 32'h0);
    check("abort in_ready", {31'b0, in_ready}, 32'h1);
    check("abort d", {16'b0, d}, 32'h0);
    check("abort bout", {31'b0, bout}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      check("post-abort out_valid", {31'b0, out_valid}, 32'h0);
    end

    // Random traffic; the compare process does the checking
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 7))
        0:       begin a = 16'($urandom); b = a; end
        1:       begin a = '0; b = 16'($urandom_range(0, 3)); end
        2:       begin a = 16'hFFFF; b = 16'($urandom); end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      bin       = 1'($urandom);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (NS + 3) @(posedge clk);

    // Exhaustive 4-bit sweep
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #1;
      a4 = 4'(i); b4 = 4'(i >> 4); bin4 = 1'(i >> 8); iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 4 && !got; n++) begin
        @(negedge clk);
        got = ov4;
        if (got) check("w4 latency", n, 1);
      end
      e4 = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
      check("w4 valid", {31'b0, got}, 32'h1);
      check("w4 result", {27'b0, bout4, d4}, {27'b0, e4});
`ifdef CLA_SUB_SIGNED_OVF_EN
      check("w4 ovf", {31'b0, ovf4},
            {31'b0, signed_ovf(int'($signed(a4)), int'($signed(b4)), int'({31'b0, bin4}), 4)});
`endif
    end

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
